adc_dat_demux_async: RTL and testbench
======================================

Name: adc_dat_demux_async

Overview:
- Reader-side parser for ASYNC-mode fills read back from DDR3.
- Consumes the 132-bit tagged word stream from the DDR3 read FIFO: 4-bit tag plus 128-bit payload; tags 1 = fill header, 2 = waveform header, 3 = data, 4 = checksum.
- Validates framing, field consistency, sign extension and the XOR checksum.
- Emits decoded header fields and an 8-sample ADC stream toward the readout/IPbus side.

Parameters:
- WDOG_LIMIT, 16'hFFFF: idle cycles allowed mid-fill with no input word before a timeout error.
- HDR_TAG, 2'b01: required value of payload[127:126] in both header types.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- in_dat  in  132  tagged word: [131:128] tag, [127:0] payload
- in_valid  in  1  in_dat valid
- in_ready  out  1  word accepted when in_valid && in_ready
- smp_dat  out  96  8 x 12-bit samples; sample0 in [11:0], oldest first
- smp_valid  out  1  smp_dat valid
- smp_ready  in  1  downstream accepts smp_dat
- fill_num  out  24  fill header [23:0]
- fill_type  out  2  fill header [25:24]
- fill_bursts  out  23  fill header [49:27]
- fill_wfm_cnt  out  23  fill header [98:76]
- chan_tag  out  16  fill header [125:110]
- wfm_idx  out  23  current waveform header [74:52]
- wfm_bursts  out  11  waveform header [10:0]
- wfm_pre_trig  out  12  waveform header [22:11]
- wfm_start_adr  out  26  waveform header [51:26]
- wfm_hdr_stb  out  1  one-cycle pulse when a waveform header is accepted
- fill_done  out  1  one-cycle pulse at fill end, on success or error
- fill_err  out  7  sticky per fill: [0] tag, [1] hdr, [2] seq, [3] sext, [4] len, [5] chk, [6] timeout

Behaviour:
- Reset: FSM to IDLE; all outputs and registers 0; in_ready = 0 during reset, 1 in IDLE the cycle after.
- FSM states: IDLE, WHDR, DATA, CSUM, FLUSH.
- Transitions:
  - IDLE: tag 1 -> latch fill fields, load checksum = payload, word_cnt = 1, wfm_cnt = 0; go WHDR, or CSUM if fill_wfm_cnt == 0. Any other tag -> discard silently.
  - WHDR: tag 2 -> latch waveform fields, pulse wfm_hdr_stb, XOR into checksum; go DATA, or (wfm_bursts == 0) the next WHDR/CSUM.
  - DATA: tag 3 -> present samples, XOR into checksum, decrement burst_cnt; at 0, wfm_cnt++; go WHDR if wfm_cnt < fill_wfm_cnt, else CSUM.
  - CSUM: tag 4 -> word_cnt++; compare payload with checksum, set err[5] on mismatch; check word_cnt == fill_bursts, set err[4] on mismatch; pulse fill_done; go IDLE.
- word_cnt counts every accepted word from the fill header through the checksum inclusive.
- Header checks:
  - payload[127:126] != HDR_TAG -> err[1].
  - Fill header bit 26 != 1, or waveform header bit 25 != 1 -> err[1].
  - Waveform fill_type or chan_tag [113:98] differing from the fill header -> err[1].
- Sequence check: waveform indices must be 0,1,...,fill_wfm_cnt-1 in order, else err[2]. Processing continues.
- Wrong tag in WHDR/DATA/CSUM -> err[0]. Then:
  - if the offending tag is 1: pulse fill_done with the error, restart as a new fill header in the same cycle;
  - otherwise: pulse fill_done, go FLUSH. FLUSH discards words until tag 1, handled as in IDLE.
- Sample unpack: lane k of payload [16k+15:16k] -> smp_dat[12k+11:12k] = payload[16k+11:16k].
- Data handshake:
  - smp_valid registered, 1-cycle latency from acceptance.
  - In DATA, in_ready = !smp_valid || smp_ready.
  - smp_valid holds with smp_dat stable until smp_ready.
  - Outside DATA, in_ready = 1.
- Watchdog: counter counts cycles with !in_valid in WHDR/DATA/CSUM; cleared on each accepted word. Reaching WDOG_LIMIT -> err[6], fill_done pulse, go FLUSH.
- fill_err clears on acceptance of a new fill header, and is held after fill_done.
- reset mid-fill: immediate return to IDLE; smp_valid drops in the same edge.

Optional Feature:
- Macro ADC_DAT_DEMUX_SEXT_CHECK_EN.
- Defined: each data lane's payload[16k+15:16k+12] must equal four copies of payload[16k+11]; any mismatch sets err[3].
- Undefined: no check, err[3] tied 0, no logic generated.

Test Plan:
- Minimal fill. Stimulus: fill hdr (fill_num 24'h000005, wfm_cnt 1, bursts 4), wfm hdr (idx 0, bursts 1), one data word with lanes 16'h0001..16'h0008, checksum = XOR of the three payloads. Response: one smp_valid with smp_dat lanes 12'h001..12'h008, fill_done with fill_err 0.
- Same fill with checksum bit 0 flipped -> fill_done, fill_err = 7'b010_0000.
- Two waveforms with indices 0 and 2 -> err[2] set, samples still delivered, fill_done after checksum.
- Data word arrives in WHDR -> err[0], fill_done pulse, FLUSH; the following valid fill parses cleanly with fill_err 0.
- smp_ready held low 10 cycles during DATA -> in_ready 0, smp_dat stable, no words lost. With SEXT_CHECK_EN, lane 16'h0801 -> err[3].
- in_valid low for WDOG_LIMIT cycles in DATA -> err[6], fill_done. reset asserted mid-DATA -> outputs 0 next cycle.

Source files
------------

// File: rtl/adc_dat_demux_async.sv
// ---------------------------------------------------------------------------
// adc_dat_demux_async
//
// Reader-side parser for ASYNC-mode fills read back from DDR3. Consumes the
// tagged 132-bit word stream (tag 1 fill header, 2 waveform header, 3 data,
// 4 checksum), validates framing, header fields, waveform sequencing, word
// count and the XOR checksum, and emits decoded header fields plus an
// 8 x 12-bit sample stream.
//
// Optional feature: define ADC_DAT_DEMUX_SEXT_CHECK_EN to check that the top
// nibble of every 16-bit data lane is a sign extension of bit 11 (err[3]).
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   in_dat/valid/ready tagged input word stream ([131:128] tag)
//   smp_dat/valid/ready 8 unpacked samples, sample0 in [11:0]
//   fill_*, chan_tag  fields latched from the fill header
//   wfm_*             fields latched from the current waveform header
//   wfm_hdr_stb       pulse per accepted waveform header
//   fill_done         pulse at fill end (success or error)
//   fill_err          sticky per-fill error flags
//                     [0] tag [1] hdr [2] seq [3] sext [4] len [5] chk [6] timeout
// ---------------------------------------------------------------------------
module adc_dat_demux_async #(
  parameter logic [15:0] WDOG_LIMIT = 16'hFFFF,
  parameter logic [1:0]  HDR_TAG    = 2'b01
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [131:0] in_dat,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [95:0]  smp_dat,
  output logic         smp_valid,
  input  logic         smp_ready,
  output logic [23:0]  fill_num,
  output logic [1:0]   fill_type,
  output logic [22:0]  fill_bursts,
  output logic [22:0]  fill_wfm_cnt,
  output logic [15:0]  chan_tag,
  output logic [22:0]  wfm_idx,
  output logic [10:0]  wfm_bursts,
  output logic [11:0]  wfm_pre_trig,
  output logic [25:0]  wfm_start_adr,
  output logic         wfm_hdr_stb,
  output logic         fill_done,
  output logic [6:0]   fill_err
);

  typedef enum logic [2:0] {IDLE, WHDR, DATA, CSUM, FLUSH} state_t;

  localparam logic [6:0] ERR_TAG  = 7'b000_0001;
  localparam logic [6:0] ERR_HDR  = 7'b000_0010;
  localparam logic [6:0] ERR_SEQ  = 7'b000_0100;
  localparam logic [6:0] ERR_SEXT = 7'b000_1000;
  localparam logic [6:0] ERR_LEN  = 7'b001_0000;
  localparam logic [6:0] ERR_CHK  = 7'b010_0000;
  localparam logic [6:0] ERR_WDOG = 7'b100_0000;

  state_t        state;
  logic          ready_en;
  logic [127:0]  checksum;
  logic [22:0]   word_cnt;
  logic [22:0]   wfm_cnt;
  logic [10:0]   burst_cnt;
  logic [15:0]   wdog_cnt;
  logic          clr_pend;
  logic [6:0]    pend_err;

  logic [3:0]    tag;
  logic [127:0]  payload;
  logic          accept;
  logic          active;
  logic          fill_hdr_bad;
  logic          wfm_hdr_bad;
  logic          sext_bad;
  logic [95:0]   smp_unpk;
  logic [6:0]    err_base;
  logic [22:0]   wfm_cnt_inc;
  logic [22:0]   word_cnt_inc;
  logic          more_wfm;

  assign tag     = in_dat[131:128];
  assign payload = in_dat[127:0];

  // ready_en keeps in_ready low through reset and for the reset cycle itself
  assign in_ready = ready_en && ((state != DATA) || !smp_valid || smp_ready);
  assign accept   = in_valid && in_ready;
  assign active   = (state == WHDR) || (state == DATA) || (state == CSUM);

  assign wfm_cnt_inc  = wfm_cnt + 23'd1;
  assign word_cnt_inc = word_cnt + 23'd1;
  assign more_wfm     = wfm_cnt_inc < fill_wfm_cnt;

  // After a restart-on-header the visible fill_err still shows the aborted
  // fill for one cycle; the new fill's flags wait in pend_err until then.
  assign err_base = clr_pend ? pend_err : fill_err;

  assign fill_hdr_bad = (payload[127:126] != HDR_TAG) || !payload[26];
  assign wfm_hdr_bad  = (payload[127:126] != HDR_TAG) || !payload[25] ||
                        (payload[24:23] != fill_type) ||
                        (payload[113:98] != chan_tag);

  // Each 16-bit lane carries a 12-bit sample in its low bits
  always_comb begin
    smp_unpk = '0;
    for (int k = 0; k < 8; k++) begin
      smp_unpk[12*k +: 12] = payload[16*k +: 12];
    end
  end

`ifdef ADC_DAT_DEMUX_SEXT_CHECK_EN
  always_comb begin
    sext_bad = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (payload[16*k+12 +: 4] != {4{payload[16*k+11]}}) begin
        sext_bad = 1'b1;
      end
    end
  end
`else
  assign sext_bad = 1'b0;
`endif

  // Main parser FSM; a tag-1 word always starts a new fill, aborting any
  // fill in progress with a tag error.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      ready_en      <= 1'b0;
      checksum      <= '0;
      word_cnt      <= '0;
      wfm_cnt       <= '0;
      burst_cnt     <= '0;
      wdog_cnt      <= '0;
      clr_pend      <= 1'b0;
      pend_err      <= '0;
      smp_dat       <= '0;
      smp_valid     <= 1'b0;
      fill_num      <= '0;
      fill_type     <= '0;
      fill_bursts   <= '0;
      fill_wfm_cnt  <= '0;
      chan_tag      <= '0;
      wfm_idx       <= '0;
      wfm_bursts    <= '0;
      wfm_pre_trig  <= '0;
      wfm_start_adr <= '0;
      wfm_hdr_stb   <= 1'b0;
      fill_done     <= 1'b0;
      fill_err      <= '0;
    end else begin
      ready_en    <= 1'b1;
      fill_done   <= 1'b0;
      wfm_hdr_stb <= 1'b0;
      if (smp_ready) smp_valid <= 1'b0;
      if (clr_pend) begin
        fill_err <= pend_err;
        clr_pend <= 1'b0;
      end
      if (accept) wdog_cnt <= '0;

      if (accept && (tag == 4'd1)) begin
        fill_num     <= payload[23:0];
        fill_type    <= payload[25:24];
        fill_bursts  <= payload[49:27];
        fill_wfm_cnt <= payload[98:76];
        chan_tag     <= payload[125:110];
        checksum     <= payload;
        word_cnt     <= 23'd1;
        wfm_cnt      <= '0;
        state        <= (payload[98:76] == 23'd0) ? CSUM : WHDR;
        if (active) begin
          fill_done <= 1'b1;
          fill_err  <= err_base | ERR_TAG;
          clr_pend  <= 1'b1;
          pend_err  <= fill_hdr_bad ? ERR_HDR : 7'd0;
        end else begin
          fill_err  <= fill_hdr_bad ? ERR_HDR : 7'd0;
          clr_pend  <= 1'b0;
        end
      end else if (accept) begin
        case (state)
          WHDR: begin
            if (tag == 4'd2) begin
              wfm_idx       <= payload[74:52];
              wfm_bursts    <= payload[10:0];
              wfm_pre_trig  <= payload[22:11];
              wfm_start_adr <= payload[51:26];
              wfm_hdr_stb   <= 1'b1;
              checksum      <= checksum ^ payload;
              word_cnt      <= word_cnt_inc;
              burst_cnt     <= payload[10:0];
              fill_err      <= err_base | (wfm_hdr_bad ? ERR_HDR : 7'd0) |
                               ((payload[74:52] != wfm_cnt) ? ERR_SEQ : 7'd0);
              // An empty waveform is complete as soon as its header lands
              if (payload[10:0] == 11'd0) begin
                wfm_cnt <= wfm_cnt_inc;
                state   <= more_wfm ? WHDR : CSUM;
              end else begin
                state   <= DATA;
              end
            end else begin
              fill_err  <= err_base | ERR_TAG;
              fill_done <= 1'b1;
              state     <= FLUSH;
            end
          end
          DATA: begin
            if (tag == 4'd3) begin
              smp_dat   <= smp_unpk;
              smp_valid <= 1'b1;
              checksum  <= checksum ^ payload;
              word_cnt  <= word_cnt_inc;
              burst_cnt <= burst_cnt - 11'd1;
              fill_err  <= err_base | (sext_bad ? ERR_SEXT : 7'd0);
              if (burst_cnt == 11'd1) begin
                wfm_cnt <= wfm_cnt_inc;
                state   <= more_wfm ? WHDR : CSUM;
              end
            end else begin
              fill_err  <= err_base | ERR_TAG;
              fill_done <= 1'b1;
              state     <= FLUSH;
            end
          end
          CSUM: begin
            fill_done <= 1'b1;
            if (tag == 4'd4) begin
              word_cnt <= word_cnt_inc;
              fill_err <= err_base |
                          ((payload != checksum) ? ERR_CHK : 7'd0) |
                          ((word_cnt_inc != fill_bursts) ? ERR_LEN : 7'd0);
              state    <= IDLE;
            end else begin
              fill_err <= err_base | ERR_TAG;
              state    <= FLUSH;
            end
          end
          default: begin
          end
        endcase
      end else if (active && !in_valid) begin
        // Watchdog only advances while the source is silent mid-fill
        if (wdog_cnt == (WDOG_LIMIT - 16'd1)) begin
          wdog_cnt  <= '0;
          fill_err  <= err_base | ERR_WDOG;
          fill_done <= 1'b1;
          state     <= FLUSH;
        end else begin
          wdog_cnt  <= wdog_cnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_adc_dat_demux_async.sv
// ---------------------------------------------------------------------------
// tb_adc_dat_demux_async
//
// Directed self-checking bench for adc_dat_demux_async. Builds fill and
// waveform headers field by field, drives the tagged word stream, and checks
// decoded fields, samples, handshake, error flags and the watchdog.
// ---------------------------------------------------------------------------
module tb_adc_dat_demux_async;

  localparam logic [15:0] WDOG = 16'd40;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [131:0] in_dat = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [95:0]  smp_dat;
  logic         smp_valid;
  logic         smp_ready = 1'b1;
  logic [23:0]  fill_num;
  logic [1:0]   fill_type;
  logic [22:0]  fill_bursts;
  logic [22:0]  fill_wfm_cnt;
  logic [15:0]  chan_tag;
  logic [22:0]  wfm_idx;
  logic [10:0]  wfm_bursts;
  logic [11:0]  wfm_pre_trig;
  logic [25:0]  wfm_start_adr;
  logic         wfm_hdr_stb;
  logic         fill_done;
  logic [6:0]   fill_err;

  int checks = 0;
  int fails  = 0;

  logic [127:0] f, w, w2, d, d2, c;
  int           cycles;
  logic         seen;

  adc_dat_demux_async #(.WDOG_LIMIT(WDOG), .HDR_TAG(2'b01)) dut (
    .clk(clk), .reset(reset),
    .in_dat(in_dat), .in_valid(in_valid), .in_ready(in_ready),
    .smp_dat(smp_dat), .smp_valid(smp_valid), .smp_ready(smp_ready),
    .fill_num(fill_num), .fill_type(fill_type), .fill_bursts(fill_bursts),
    .fill_wfm_cnt(fill_wfm_cnt), .chan_tag(chan_tag),
    .wfm_idx(wfm_idx), .wfm_bursts(wfm_bursts), .wfm_pre_trig(wfm_pre_trig),
    .wfm_start_adr(wfm_start_adr), .wfm_hdr_stb(wfm_hdr_stb),
    .fill_done(fill_done), .fill_err(fill_err)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("[TB] FAIL global_timeout: observed no end of test, expected end of test");
    $fatal(1, "[TB] simulation time limit");
  end

  function automatic logic [127:0] fill_hdr(input logic [23:0] num, input logic [1:0] typ,
                                            input logic [22:0] bursts, input logic [22:0] wcnt,
                                            input logic [15:0] chan);
    logic [127:0] p;
    p = '0;
    p[127:126] = 2'b01;
    p[125:110] = chan;
    p[98:76]   = wcnt;
    p[49:27]   = bursts;
    p[26]      = 1'b1;
    p[25:24]   = typ;
    p[23:0]    = num;
    return p;
  endfunction

  function automatic logic [127:0] wfm_hdr(input logic [22:0] idx, input logic [10:0] bursts,
                                           input logic [11:0] pre, input logic [25:0] adr,
                                           input logic [1:0] typ, input logic [15:0] chan);
    logic [127:0] p;
    p = '0;
    p[127:126] = 2'b01;
    p[113:98]  = chan;
    p[74:52]   = idx;
    p[51:26]   = adr;
    p[25]      = 1'b1;
    p[24:23]   = typ;
    p[22:11]   = pre;
    p[10:0]    = bursts;
    return p;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", name, obs, exp);
    end
  endtask

  // Presents one word from a falling edge and holds it until accepted; returns
  // 1 time unit after the accepting rising edge with in_valid dropped.
  task automatic applyStimulus(input logic [3:0] tag, input logic [127:0] p);
    int n;
    @(negedge clk);
    in_dat   = {tag, p};
    in_valid = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput("in_ready_wait", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    $display("[TB] start");
    // ---- reset ----
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", in_ready, 1'b0);
    checkOutput("rst_smp_valid", smp_valid, 1'b0);
    checkOutput("rst_fill_done", fill_done, 1'b0);
    checkOutput("rst_fill_err", fill_err, 7'd0);
    checkOutput("rst_fill_num", fill_num, 24'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("idle_in_ready", in_ready, 1'b1);

    // ---- minimal fill ----
    f = fill_hdr(24'h000005, 2'b10, 23'd4, 23'd1, 16'hABCD);
    w = wfm_hdr(23'd0, 11'd1, 12'h123, 26'h0000040, 2'b10, 16'hABCD);
    d = 128'h0008_0007_0006_0005_0004_0003_0002_0001;
    c = f ^ w ^ d;
    applyStimulus(4'd1, f);
    checkOutput("min_fill_num", fill_num, 24'h000005);
    checkOutput("min_fill_type", fill_type, 2'b10);
    checkOutput("min_fill_bursts", fill_bursts, 23'd4);
    checkOutput("min_fill_wfm_cnt", fill_wfm_cnt, 23'd1);
    checkOutput("min_chan_tag", chan_tag, 16'hABCD);
    applyStimulus(4'd2, w);
    checkOutput("min_wfm_stb", wfm_hdr_stb, 1'b1);
    checkOutput("min_wfm_bursts", wfm_bursts, 11'd1);
    checkOutput("min_wfm_pre_trig", wfm_pre_trig, 12'h123);
    checkOutput("min_wfm_start_adr", wfm_start_adr, 26'h0000040);
    checkOutput("min_wfm_idx", wfm_idx, 23'd0);
    applyStimulus(4'd3, d);
    checkOutput("min_smp_valid", smp_valid, 1'b1);
    checkOutput("min_smp_dat", smp_dat, 96'h008_007_006_005_004_003_002_001);
    applyStimulus(4'd4, c);
    checkOutput("min_fill_done", fill_done, 1'b1);
    checkOutput("min_fill_err", fill_err, 7'd0);
    @(posedge clk);
    #1;
    checkOutput("min_done_pulse", fill_done, 1'b0);
    checkOutput("min_smp_drop", smp_valid, 1'b0);

    // ---- bad checksum ----
    applyStimulus(4'd1, f);
    applyStimulus(4'd2, w);
    applyStimulus(4'd3, d);
    applyStimulus(4'd4, c ^ 128'd1);
    checkOutput("chk_fill_done", fill_done, 1'b1);
    checkOutput("chk_fill_err", fill_err, 7'b010_0000);

    // ---- waveform index gap 0, 2 ----
    f  = fill_hdr(24'h000006, 2'b01, 23'd6, 23'd2, 16'h1234);
    w  = wfm_hdr(23'd0, 11'd1, 12'h010, 26'h0000100, 2'b01, 16'h1234);
    w2 = wfm_hdr(23'd2, 11'd1, 12'h020, 26'h0000200, 2'b01, 16'h1234);
    d2 = 128'h0018_0017_0016_0015_0014_0013_0012_0011;
    c  = f ^ w ^ d ^ w2 ^ d2;
    applyStimulus(4'd1, f);
    checkOutput("seq_fill_err_clear", fill_err, 7'd0);
    applyStimulus(4'd2, w);
    applyStimulus(4'd3, d);
    checkOutput("seq_smp0", smp_dat, 96'h008_007_006_005_004_003_002_001);
    applyStimulus(4'd2, w2);
    checkOutput("seq_err_mid", fill_err, 7'b000_0100);
    checkOutput("seq_wfm_idx", wfm_idx, 23'd2);
    applyStimulus(4'd3, d2);
    checkOutput("seq_smp1_valid", smp_valid, 1'b1);
    checkOutput("seq_smp1", smp_dat, 96'h018_017_016_015_014_013_012_011);
    applyStimulus(4'd4, c);
    checkOutput("seq_fill_done", fill_done, 1'b1);
    checkOutput("seq_fill_err", fill_err, 7'b000_0100);

    // ---- data word in WHDR, flush, then clean fill ----
    f = fill_hdr(24'h000007, 2'b10, 23'd4, 23'd1, 16'hABCD);
    w = wfm_hdr(23'd0, 11'd1, 12'h123, 26'h0000040, 2'b10, 16'hABCD);
    c = f ^ w ^ d;
    applyStimulus(4'd1, f);
    applyStimulus(4'd3, d);
    checkOutput("tag_fill_done", fill_done, 1'b1);
    checkOutput("tag_fill_err", fill_err, 7'b000_0001);
    applyStimulus(4'd3, d);
    checkOutput("flush_no_done", fill_done, 1'b0);
    checkOutput("flush_no_smp", smp_valid, 1'b0);
    applyStimulus(4'd1, f);
    checkOutput("flush_err_clear", fill_err, 7'd0);
    applyStimulus(4'd2, w);
    applyStimulus(4'd3, d);
    applyStimulus(4'd4, c);
    checkOutput("flush_fill_done", fill_done, 1'b1);
    checkOutput("flush_fill_err", fill_err, 7'd0);

    // ---- empty fill (no waveforms) ----
    f = fill_hdr(24'h000008, 2'b00, 23'd2, 23'd0, 16'h5555);
    applyStimulus(4'd1, f);
    applyStimulus(4'd4, f);
    checkOutput("empty_fill_done", fill_done, 1'b1);
    checkOutput("empty_fill_err", fill_err, 7'd0);

    // ---- backpressure: smp_ready low for 10 cycles ----
    f  = fill_hdr(24'h000009, 2'b11, 23'd5, 23'd1, 16'h0F0F);
    w  = wfm_hdr(23'd0, 11'd2, 12'hFFF, 26'h3FFFFFF, 2'b11, 16'h0F0F);
    d2 = 128'hF800_07FF_0010_0020_FFFF_0000_FABC_0123;
    c  = f ^ w ^ d ^ d2;
    applyStimulus(4'd1, f);
    applyStimulus(4'd2, w);
    smp_ready = 1'b0;
    applyStimulus(4'd3, d);
    checkOutput("bp_smp_valid", smp_valid, 1'b1);
    @(negedge clk);
    in_dat   = {4'd3, d2};
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      checkOutput("bp_in_ready_low", in_ready, 1'b0);
      checkOutput("bp_smp_stable", smp_dat, 96'h008_007_006_005_004_003_002_001);
      @(negedge clk);
    end
    smp_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkOutput("bp_smp2_valid", smp_valid, 1'b1);
    checkOutput("bp_smp2", smp_dat, 96'h800_7FF_010_020_FFF_000_ABC_123);
    applyStimulus(4'd4, c);
    checkOutput("bp_fill_done", fill_done, 1'b1);
    checkOutput("bp_fill_err", fill_err, 7'd0);

    // ---- sign-extension lane 16'h0801 ----
    f = fill_hdr(24'h00000A, 2'b10, 23'd4, 23'd1, 16'hABCD);
    w = wfm_hdr(23'd0, 11'd1, 12'h123, 26'h0000040, 2'b10, 16'hABCD);
    d = 128'h0008_0007_0006_0005_0004_0003_0002_0801;
    c = f ^ w ^ d;
    applyStimulus(4'd1, f);
    applyStimulus(4'd2, w);
    applyStimulus(4'd3, d);
    checkOutput("sext_smp", smp_dat, 96'h008_007_006_005_004_003_002_801);
    applyStimulus(4'd4, c);
`ifdef ADC_DAT_DEMUX_SEXT_CHECK_EN
    checkOutput("sext_fill_err", fill_err, 7'b000_1000);
`else
    checkOutput("sext_fill_err", fill_err, 7'd0);
`endif

    // ---- watchdog timeout in DATA ----
    f = fill_hdr(24'h00000B, 2'b10, 23'd5, 23'd1, 16'hABCD);
    w = wfm_hdr(23'd0, 11'd2, 12'h123, 26'h0000040, 2'b10, 16'hABCD);
    d = 128'h0008_0007_0006_0005_0004_0003_0002_0001;
    applyStimulus(4'd1, f);
    applyStimulus(4'd2, w);
    applyStimulus(4'd3, d);
    cycles = 0;
    seen   = 1'b0;
    while (!seen && cycles < 200) begin
      @(posedge clk);
      #1;
      cycles++;
      seen = fill_done;
    end
    checkOutput("wdog_done_seen", seen, 1'b1);
    checkOutput("wdog_cycles", cycles, WDOG);
    checkOutput("wdog_fill_err", fill_err, 7'b100_0000);

    // ---- reset mid-DATA ----
    applyStimulus(4'd1, f);
    applyStimulus(4'd2, w);
    smp_ready = 1'b0;
    applyStimulus(4'd3, d);
    checkOutput("mrst_pre_smp_valid", smp_valid, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("mrst_smp_valid", smp_valid, 1'b0);
    checkOutput("mrst_smp_dat", smp_dat, 96'd0);
    checkOutput("mrst_fill_num", fill_num, 24'd0);
    checkOutput("mrst_wfm_bursts", wfm_bursts, 11'd0);
    checkOutput("mrst_in_ready", in_ready, 1'b0);
    @(negedge clk);
    reset     = 1'b0;
    smp_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("mrst_idle_ready", in_ready, 1'b1);
    checkOutput("mrst_fill_err", fill_err, 7'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
